// File: rtl/approx_mul_sched_pkg.sv
// approx_mul_pkg: shared widths and pipeline entry types for approx_mul_sched.
package approx_mul_pkg;
    localparam int OP_W = 8;
    localparam int RES_W = 16;
    localparam int MASK_W = 6;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic              id;
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [MASK_W-1:0] mask;
    } s1_t;

    typedef struct packed {
        logic             id;
        logic [RES_W-1:0] r;
        logic [RES_W-1:0] exact;
        logic             err;
    } s2_t;
endpackage

// File: rtl/approx_mul_sched_if.sv
// approx_mul_sched_if: request/response/statistics bundle of approx_mul_sched.
interface approx_mul_sched_if;
    import approx_mul_pkg::*;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_a0, req_a1, req_b0, req_b1;
    logic [MASK_W-1:0] req_mask0, req_mask1;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [RES_W-1:0]  rsp_r, rsp_exact;
    logic              stats_clr;
    logic [CNT_W-1:0]  tx_cnt, err_cnt;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_mask0, req_mask1, rsp_ready, stats_clr,
        input  req_ready, rsp_valid, rsp_id, rsp_r, rsp_exact, rsp_err, tx_cnt, err_cnt
    );
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_mask0, req_mask1, rsp_ready, stats_clr,
        output req_ready, rsp_valid, rsp_id, rsp_r, rsp_exact, rsp_err, tx_cnt, err_cnt
    );
endinterface

// File: rtl/approx_mul_sched_arb.sv
// rr_arb2: 2-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant;

    assign grant = req == 2'b11 ? (last_grant ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_grant <= 1'b1;
        else if (accept) last_grant <= grant[1];
endmodule

// File: rtl/approx_mul_sched_mul.sv
// unsigned_int_mul: array multiplier whose result columns below MASK_W are dropped
// wherever the matching Conf_Bit_Mask bit is 0.
module unsigned_int_mul
    import approx_mul_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [MASK_W-1:0] mask,
    output logic [RES_W-1:0]  r
);
    logic [RES_W-1:0] keep;

    assign keep = {{(RES_W-MASK_W){1'b1}}, mask};

    always_comb begin
        r = '0;
        for (int i = 0; i < OP_W; i++)
            r = r + ((RES_W'(b & {OP_W{a[i]}}) << i) & keep);
    end
endmodule

// File: rtl/approx_mul_sched.sv
// approx_mul_sched: two requesters share one approximate multiplier through a
// round-robin arbiter and a two-stage pipeline with response backpressure and statistics.
module approx_mul_sched
    import approx_mul_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    approx_mul_sched_if.slave bus
);
    s1_t              s1, s1_in;
    s2_t              s2;
    logic             s1_v, s2_v, s2_load, accept_ok, accept, hs;
    logic [1:0]       grant;
    logic [RES_W-1:0] r, exact;
    logic [CNT_W-1:0] tx, errs;

    rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req(bus.req_valid), .accept(accept), .grant(grant));

    assign s2_load = s1_v && (!s2_v || bus.rsp_ready);
    assign accept_ok = !s1_v || s2_load;
    // rst_n gates ready so nothing looks acceptable while the block is held in reset
    assign bus.req_ready = grant & {2{accept_ok && rst_n}};
    assign accept = |(bus.req_valid & bus.req_ready);
    assign s1_in = grant[1] ? '{1'b1, bus.req_a1, bus.req_b1, bus.req_mask1}
                            : '{1'b0, bus.req_a0, bus.req_b0, bus.req_mask0};
    assign hs = s2_v && bus.rsp_ready;

    unsigned_int_mul u_mul (.a(s1.a), .b(s1.b), .mask(s1.mask), .r(r));

    assign exact = RES_W'(s1.a) * RES_W'(s1.b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            tx   <= '0;
            errs <= '0;
        end else begin
            if (accept) s1 <= s1_in;
            s1_v <= accept || (s1_v && !s2_load);
            if (s2_load) s2 <= '{s1.id, r, exact, r != exact};
            s2_v <= s2_load || (s2_v && !bus.rsp_ready);
            tx   <= bus.stats_clr ? '0 : tx + CNT_W'(hs && tx != '1);
            errs <= bus.stats_clr ? '0 : errs + CNT_W'(hs && s2.err && errs != '1);
        end
    end

    assign bus.rsp_valid = s2_v;
    assign bus.rsp_id    = s2.id;
    assign bus.rsp_r     = s2.r;
    assign bus.rsp_exact = s2.exact;
    assign bus.rsp_err   = s2.err;
    assign bus.tx_cnt    = tx;
    assign bus.err_cnt   = errs;
endmodule

// File: tb/tb_approx_mul_sched.sv
// tb_approx_mul_sched: directed and random stimulus against a queue-based model of
// the scheduler and an arithmetic model of the column-masked multiplier.
module tb_approx_mul_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_mul_sched_if bus ();
    approx_mul_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit          id;
        logic [15:0] r;
        logic [15:0] ex;
        bit          err;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   compared = 0, mismatched = 0, cyc_n = 0, tx_m = 0, er_m = 0;
    bit   last_g = 1'b1, acc0, acc1;

    // exact product minus every dropped low column, counted as AND-ed bit pairs
    function automatic logic [15:0] gold(input logic [7:0] a, b, input logic [5:0] m);
        int p = int'(a) * int'(b);
        for (int k = 0; k < 6; k++)
            if (!m[k])
                for (int i = 0; i <= k; i++)
                    if (a[i] && b[k-i]) p -= (1 << k);
        return 16'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] a0, b0, input logic [5:0] m0,
                         input logic [7:0] a1, b1, input logic [5:0] m1, input logic rdy);
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_mask0 = m0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_mask1 = m1;
        bus.rsp_ready = rdy;
    endtask

    task automatic drive_rand(input logic [1:0] v, input logic rdy);
        drive(v, 8'($urandom), 8'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 6'($urandom), rdy);
    endtask

    // one clock: check all outputs against the model just before the edge, then advance the model
    task automatic cyc();
        logic [1:0] v, g, exp_rdy;
        bit vexp, hs;
        ent_t e;
        #2;
        if (!rst_n) begin
            q.delete();
            last_g = 1'b1; tx_m = 0; er_m = 0; acc0 = 0; acc1 = 0;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data", {bus.rsp_id, bus.rsp_err, bus.rsp_r}, 0);
            chk("rst_tx_cnt", bus.tx_cnt, 0);
            chk("rst_err_cnt", bus.err_cnt, 0);
        end else begin
            v = bus.req_valid;
            g = v == 2'b11 ? (last_g ? 2'b01 : 2'b10) : v;
            exp_rdy = (q.size() < 2 || bus.rsp_ready) ? g : 2'b00;
            chk("req_ready", bus.req_ready, exp_rdy);
            vexp = q.size() > 0 && q[0].stamp <= cyc_n - 2;
            chk("rsp_valid", bus.rsp_valid, vexp);
            if (vexp) begin
                chk("rsp_id", bus.rsp_id, q[0].id);
                chk("rsp_r", bus.rsp_r, q[0].r);
                chk("rsp_exact", bus.rsp_exact, q[0].ex);
                chk("rsp_err", bus.rsp_err, q[0].err);
            end
            chk("tx_cnt", bus.tx_cnt, tx_m);
            chk("err_cnt", bus.err_cnt, er_m);
            hs = vexp && bus.rsp_ready;
            acc0 = exp_rdy[0]; acc1 = exp_rdy[1];
            if (bus.stats_clr) begin
                tx_m = 0; er_m = 0;
            end else if (hs) begin
                if (tx_m < 65535) tx_m++;
                if (q[0].err && er_m < 65535) er_m++;
            end
            if (hs) void'(q.pop_front());
            if (acc0 || acc1) begin
                e.id = acc1;
                e.r = acc1 ? gold(bus.req_a1, bus.req_b1, bus.req_mask1) : gold(bus.req_a0, bus.req_b0, bus.req_mask0);
                e.ex = acc1 ? 16'(bus.req_a1 * bus.req_b1) : 16'(bus.req_a0 * bus.req_b0);
                e.err = e.r != e.ex;
                e.stamp = cyc_n;
                q.push_back(e);
                last_g = acc1;
            end
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        int n_acc, idx, gold_err;
        bit prev0;
        bus.stats_clr = 1'b0;
        drive_rand(2'b11, 1'b1);
        @(negedge clk);
        repeat (3) cyc();
        rst_n = 1'b1;
        drive_rand(2'b00, 1'b1);
        cyc();

        // single request on requester 0
        drive(2'b01, 8'd12, 8'd10, 6'b111111, 8'd0, 8'd0, 6'd0, 1'b1);
        cyc();
        chk("single_accept", acc0, 1);
        drive(2'b00, 8'd0, 8'd0, 6'd0, 8'd0, 8'd0, 6'd0, 1'b1);
        chk("single_not_yet", bus.rsp_valid, 0);
        cyc();
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_id", bus.rsp_id, 0);
        chk("single_exact", bus.rsp_exact, 120);
        chk("single_r", bus.rsp_r, gold(8'd12, 8'd10, 6'b111111));
        repeat (2) cyc();

        // contention: grants alternate, one response per cycle
        drive_rand(2'b11, 1'b1);
        cyc();
        prev0 = acc0;
        for (int i = 0; i < 10; i++) begin
            drive_rand(2'b11, 1'b1);
            cyc();
            chk("contend_alternate", acc0, !prev0);
            prev0 = acc0;
        end
        drive_rand(2'b00, 1'b1);
        repeat (3) cyc();

        // backpressure from an empty pipeline
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(2'b11, 1'b0);
            cyc();
            n_acc += int'(acc0) + int'(acc1);
        end
        chk("bp_accepts", n_acc, 2);
        for (int i = 0; i < 6; i++) begin
            drive_rand(2'b11, 1'b1);
            cyc();
        end
        drive_rand(2'b00, 1'b1);
        repeat (3) cyc();

        // random traffic with mixed masks, stalls and clears
        for (int i = 0; i < 400; i++) begin
            drive_rand(2'($urandom), $urandom_range(0, 3) != 0);
            bus.stats_clr = $urandom_range(0, 39) == 0;
            cyc();
        end
        bus.stats_clr = 1'b0;
        drive_rand(2'b00, 1'b1);
        repeat (3) cyc();

        // clear coinciding with a handshake
        drive(2'b10, 8'd200, 8'd99, 6'b000000, 8'd200, 8'd99, 6'b000000, 1'b1);
        cyc();
        drive_rand(2'b00, 1'b1);
        cyc();
        chk("clr_hs_valid", bus.rsp_valid, 1);
        bus.stats_clr = 1'b1;
        cyc();
        bus.stats_clr = 1'b0;
        chk("clr_hs_tx", bus.tx_cnt, 0);
        chk("clr_hs_err", bus.err_cnt, 0);

        // reset with S1 and S2 both full
        for (int i = 0; i < 3; i++) begin
            drive_rand(2'b01, 1'b0);
            cyc();
        end
        chk("full_valid", bus.rsp_valid, 1);
        drive_rand(2'b00, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.rsp_valid, 0);
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        // exhaustive sweep on requester 0 with mask 000111
        bus.stats_clr = 1'b1;
        cyc();
        bus.stats_clr = 1'b0;
        idx = 0;
        gold_err = 0;
        for (int n = 0; n < 70000 && idx < 65536; n++) begin
            drive(2'b01, idx[15:8], idx[7:0], 6'b000111, 8'd0, 8'd0, 6'd0, 1'b1);
            cyc();
            if (acc0) begin
                if (gold(idx[15:8], idx[7:0], 6'b000111) != 16'(idx[15:8] * idx[7:0])) gold_err++;
                idx++;
            end
        end
        chk("sweep_done", idx, 65536);
        drive_rand(2'b00, 1'b1);
        repeat (3) cyc();
        chk("sweep_tx", bus.tx_cnt, 16'hFFFF);
        chk("sweep_err", bus.err_cnt, gold_err > 65535 ? 16'hFFFF : gold_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
